// File: rtl/div_ctrl.sv
// Multi-cycle restoring divider for MIPS DIV/DIVU in EX.
// Stalls the pipe while iterating, then pulses ready with {HI, LO}.
module div_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        signed_div,
  input  logic [31:0] opdata1,
  input  logic [31:0] opdata2,
  input  logic        annul,
  output logic        stall_o,
  output logic        ready_o,
  output logic [63:0] result_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ZERO,
    S_RUN,
    S_DONE
  } state_e;

  state_e      state_q;
  logic [5:0]  cnt_q;
  logic [64:0] wr_q;
  logic [31:0] dvsr_q;
  logic        qsign_q;
  logic        rsign_q;
  logic [63:0] result_q;
  logic        ready_q;

  logic [64:0] sh;
  logic [32:0] diff;
  logic [64:0] step;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] lo_fix;
  logic [31:0] hi_fix;
  logic [31:0] abs_a;
  logic [31:0] abs_b;

  // One restoring iteration on {rem, quo}
  always_comb begin
    sh   = wr_q << 1;
    diff = sh[64:32] - {1'b0, dvsr_q};
    step = sh;
    if (!diff[32]) begin
      step = {diff, sh[31:1], 1'b1};
    end
    quo    = step[31:0];
    rem    = step[63:32];
    lo_fix = qsign_q ? -quo : quo;
    hi_fix = rsign_q ? -rem : rem;
  end

  always_comb begin
    abs_a = opdata1;
    abs_b = opdata2;
    if (signed_div && opdata1[31]) begin
      abs_a = -opdata1;
    end
    if (signed_div && opdata2[31]) begin
      abs_b = -opdata2;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      wr_q     <= '0;
      dvsr_q   <= '0;
      qsign_q  <= 1'b0;
      rsign_q  <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && !annul) begin
            wr_q    <= {33'b0, abs_a};
            dvsr_q  <= abs_b;
            qsign_q <= signed_div & (opdata1[31] ^ opdata2[31]);
            rsign_q <= signed_div & opdata1[31];
            cnt_q   <= '0;
            state_q <= (opdata2 == 32'd0) ? S_ZERO : S_RUN;
          end
        end
        S_ZERO: begin
          if (annul) begin
            state_q <= S_IDLE;
          end else begin
            state_q  <= S_DONE;
            ready_q  <= 1'b1;
            result_q <= {wr_q[31:0], 32'hFFFF_FFFF};
          end
        end
        S_RUN: begin
          if (annul) begin
            state_q <= S_IDLE;
          end else begin
            wr_q  <= step;
            cnt_q <= cnt_q + 6'd1;
            if (cnt_q == 6'd31) begin
              state_q  <= S_DONE;
              ready_q  <= 1'b1;
              result_q <= {hi_fix, lo_fix};
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // A flush landing on DONE suppresses the HI/LO write
  assign ready_o  = ready_q & ~annul;
  assign result_o = result_q;
  assign stall_o  = ((state_q == S_IDLE) & start & ~annul)
                  | (state_q == S_ZERO)
                  | (state_q == S_RUN);

endmodule

// File: tb/tb_div_ctrl.sv
// Directed-vector bench for div_ctrl.
// One task per scenario, each with its own inline comparisons.
module tb_div_ctrl;

  logic        clk;
  logic        resetn;
  logic        start;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        annul;
  logic        stall_o;
  logic        ready_o;
  logic [63:0] result_o;

  int n_vec;
  int n_err;

  div_ctrl dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .signed_div (signed_div),
    .opdata1    (opdata1),
    .opdata2    (opdata2),
    .annul      (annul),
    .stall_o    (stall_o),
    .ready_o    (ready_o),
    .result_o   (result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_div(input logic s, input logic [31:0] a,
                        input logic [31:0] b, output int rdy,
                        output int nstall, output logic [63:0] res);
    rdy = -1;
    nstall = 0;
    res = '0;
    start = 1'b1;
    signed_div = s;
    opdata1 = a;
    opdata2 = b;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (stall_o) nstall++;
      if (ready_o) begin
        rdy = c;
        res = result_o;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    resetn = 1'b1;
    #1;
    resetn = 1'b0;
    #1;
    n_vec++;
    if (stall_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_stall got %b exp 0", stall_o);
    end
    n_vec++;
    if (ready_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ready got %b exp 0", ready_o);
    end
    n_vec++;
    if (result_o !== 64'd0) begin
      n_err++;
      $display("FAIL reset_result got %h exp 0", result_o);
    end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_divu_basic();
    int rdy;
    int ns;
    logic [63:0] res;
    do_div(1'b0, 32'd100, 32'd7, rdy, ns, res);
    n_vec++;
    if (rdy !== 33) begin
      n_err++;
      $display("FAIL basic_ready_cycle got %0d exp 33", rdy);
    end
    n_vec++;
    if (ns !== 33) begin
      n_err++;
      $display("FAIL basic_stall_cycles got %0d exp 33", ns);
    end
    n_vec++;
    if (res !== {32'd2, 32'd14}) begin
      n_err++;
      $display("FAIL basic_result got %h exp %h", res, {32'd2, 32'd14});
    end
    #1;
    n_vec++;
    if (ready_o !== 1'b0) begin
      n_err++;
      $display("FAIL basic_ready_pulse got %b exp 0", ready_o);
    end
    n_vec++;
    if (result_o !== {32'd2, 32'd14}) begin
      n_err++;
      $display("FAIL basic_result_hold got %h exp %h", result_o, {32'd2, 32'd14});
    end
  endtask

  task automatic test_signed();
    int rdy;
    int ns;
    logic [63:0] res;
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, rdy, ns, res);
    n_vec++;
    if (res !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
      n_err++;
      $display("FAIL sdiv_m7_2 got %h exp ffffffff_fffffffd", res);
    end
    do_div(1'b1, 32'd7, 32'hFFFF_FFFE, rdy, ns, res);
    n_vec++;
    if (res !== {32'd1, 32'hFFFF_FFFD}) begin
      n_err++;
      $display("FAIL sdiv_7_m2 got %h exp 00000001_fffffffd", res);
    end
    do_div(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, rdy, ns, res);
    n_vec++;
    if (res !== {32'hFFFF_FFFE, 32'd14}) begin
      n_err++;
      $display("FAIL sdiv_m100_m7 got %h exp fffffffe_0000000e", res);
    end
  endtask

  task automatic test_special();
    int rdy;
    int ns;
    logic [63:0] res;
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, rdy, ns, res);
    n_vec++;
    if (res !== {32'd0, 32'h8000_0000}) begin
      n_err++;
      $display("FAIL sdiv_minint got %h exp 00000000_80000000", res);
    end
    do_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, rdy, ns, res);
    n_vec++;
    if (res !== {32'h8000_0000, 32'd0}) begin
      n_err++;
      $display("FAIL udiv_minint got %h exp 80000000_00000000", res);
    end
  endtask

  task automatic test_zero();
    int rdy;
    int ns;
    logic [63:0] res;
    do_div(1'b0, 32'd5, 32'd0, rdy, ns, res);
    n_vec++;
    if (rdy !== 2) begin
      n_err++;
      $display("FAIL zero_ready_cycle got %0d exp 2", rdy);
    end
    n_vec++;
    if (ns !== 2) begin
      n_err++;
      $display("FAIL zero_stall_cycles got %0d exp 2", ns);
    end
    n_vec++;
    if (res !== {32'd5, 32'hFFFF_FFFF}) begin
      n_err++;
      $display("FAIL zero_result got %h exp 00000005_ffffffff", res);
    end
  endtask

  task automatic test_annul();
    int early;
    int rdy;
    logic [63:0] res;
    early = 0;
    rdy = -1;
    res = '0;
    start = 1'b1;
    signed_div = 1'b0;
    opdata1 = 32'd1000;
    opdata2 = 32'd3;
    for (int c = 0; c <= 10; c++) begin
      #1;
      if (ready_o) early++;
      if (c < 10) @(negedge clk);
    end
    annul = 1'b1;
    start = 1'b0;
    @(negedge clk);
    annul = 1'b0;
    #1;
    n_vec++;
    if (stall_o !== 1'b0) begin
      n_err++;
      $display("FAIL annul_stall got %b exp 0", stall_o);
    end
    n_vec++;
    if (result_o !== {32'd5, 32'hFFFF_FFFF}) begin
      n_err++;
      $display("FAIL annul_result_hold got %h exp 00000005_ffffffff", result_o);
    end
    start = 1'b1;
    opdata1 = 32'd99;
    opdata2 = 32'd10;
    #1;
    n_vec++;
    if (stall_o !== 1'b1) begin
      n_err++;
      $display("FAIL annul_reaccept_stall got %b exp 1", stall_o);
    end
    for (int c = 12; c < 70; c++) begin
      @(negedge clk);
      #1;
      if (ready_o) begin
        rdy = c;
        res = result_o;
        break;
      end
    end
    start = 1'b0;
    @(negedge clk);
    n_vec++;
    if (early !== 0 || rdy !== 44) begin
      n_err++;
      $display("FAIL annul_ready got early=%0d cyc=%0d exp early=0 cyc=44", early, rdy);
    end
    n_vec++;
    if (res !== {32'd9, 32'd9}) begin
      n_err++;
      $display("FAIL annul_new_result got %h exp 00000009_00000009", res);
    end
  endtask

  task automatic test_annul_done();
    start = 1'b1;
    signed_div = 1'b0;
    opdata1 = 32'd9;
    opdata2 = 32'd3;
    for (int c = 0; c < 33; c++) @(negedge clk);
    #1;
    n_vec++;
    if (ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL done_ready got %b exp 1", ready_o);
    end
    annul = 1'b1;
    #1;
    n_vec++;
    if (ready_o !== 1'b0) begin
      n_err++;
      $display("FAIL done_annul_ready got %b exp 0", ready_o);
    end
    start = 1'b0;
    @(negedge clk);
    annul = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int rdy;
    int ns;
    logic [63:0] res;
    start = 1'b1;
    signed_div = 1'b0;
    opdata1 = 32'd1000;
    opdata2 = 32'd3;
    for (int c = 0; c < 20; c++) @(negedge clk);
    resetn = 1'b0;
    start = 1'b0;
    #1;
    n_vec++;
    if (stall_o !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_stall got %b exp 0", stall_o);
    end
    n_vec++;
    if (ready_o !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_ready got %b exp 0", ready_o);
    end
    n_vec++;
    if (result_o !== 64'd0) begin
      n_err++;
      $display("FAIL rstmid_result got %h exp 0", result_o);
    end
    @(negedge clk);
    resetn = 1'b1;
    do_div(1'b0, 32'd77, 32'd5, rdy, ns, res);
    n_vec++;
    if (rdy !== 33 || res !== {32'd2, 32'd15}) begin
      n_err++;
      $display("FAIL rstmid_new got cyc=%0d res=%h exp cyc=33 res=00000002_0000000f", rdy, res);
    end
  endtask

  task automatic test_back_to_back();
    int pulses;
    int r1;
    int r2;
    logic [63:0] res1;
    logic [63:0] res2;
    pulses = 0;
    r1 = -1;
    r2 = -1;
    res1 = '0;
    res2 = '0;
    start = 1'b1;
    signed_div = 1'b0;
    opdata1 = 32'd20;
    opdata2 = 32'd3;
    for (int c = 0; c < 80; c++) begin
      #1;
      if (ready_o) begin
        pulses++;
        if (r1 < 0) begin
          r1 = c;
          res1 = result_o;
        end else begin
          r2 = c;
          res2 = result_o;
        end
      end
      if (c == 34) begin
        n_vec++;
        if (stall_o !== 1'b1) begin
          n_err++;
          $display("FAIL b2b_accept_stall got %b exp 1", stall_o);
        end
      end
      if (c == 33) begin
        opdata1 = 32'd50;
        opdata2 = 32'd4;
      end
      if (c == 67) start = 1'b0;
      @(negedge clk);
    end
    n_vec++;
    if (pulses !== 2) begin
      n_err++;
      $display("FAIL b2b_pulses got %0d exp 2", pulses);
    end
    n_vec++;
    if (r1 !== 33) begin
      n_err++;
      $display("FAIL b2b_first_cycle got %0d exp 33", r1);
    end
    n_vec++;
    if (r2 !== 67) begin
      n_err++;
      $display("FAIL b2b_second_cycle got %0d exp 67", r2);
    end
    n_vec++;
    if (res1 !== {32'd2, 32'd6}) begin
      n_err++;
      $display("FAIL b2b_first_result got %h exp 00000002_00000006", res1);
    end
    n_vec++;
    if (res2 !== {32'd2, 32'd12}) begin
      n_err++;
      $display("FAIL b2b_second_result got %h exp 00000002_0000000c", res2);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    resetn = 1'b1;
    start = 1'b0;
    signed_div = 1'b0;
    opdata1 = '0;
    opdata2 = '0;
    annul = 1'b0;
    test_reset();
    test_divu_basic();
    test_signed();
    test_special();
    test_zero();
    test_annul();
    test_annul_done();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
